// File: rtl/rob_pkg.sv
// Shared defaults and entry layout for the reorder buffer.
package rob_pkg;
  localparam int ROB_DEPTH  = 8;
  localparam int ROB_DATA_W = 64;
  localparam int ROB_ADDR_W = 48;
  localparam int ROB_REG_W  = 5;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  is_mem;
    logic [ROB_REG_W-1:0]  dest;
    logic [ROB_ADDR_W-1:0] addr;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrapping W-bit ring pointer; advances one slot per enabled cycle.
// Clear takes priority over increment; no backpressure of its own.
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);
  logic [W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/rob_param.sv
// Reorder buffer: in-order alloc, out-of-order writeback by tag, in-order commit; alloc-to-commit >= 2 cycles.
// alloc_ready drops when full (pre-edge count); commit holds head until commit_ready; flush wins over everything.
module rob_param import rob_pkg::*; #(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = ROB_DATA_W,
  parameter int ADDR_W = ROB_ADDR_W,
  parameter int REG_W  = ROB_REG_W,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic              alloc_is_mem,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              commit_is_mem,
  output logic [REG_W-1:0]  commit_dest,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [TAG_W:0]    count
);
  typedef struct packed {
    logic              valid;
    logic              done;
    logic              is_mem;
    logic [REG_W-1:0]  dest;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           r_entries [DEPTH];
  logic [TAG_W:0]   r_count;
  logic [TAG_W-1:0] w_head;
  logic [TAG_W-1:0] w_tail;
  logic             w_alloc_fire;
  logic             w_commit_fire;
  logic             w_wb_hit;

  assign full          = (r_count == (TAG_W+1)'(DEPTH));
  assign empty         = (r_count == '0);
  assign count         = r_count;
  assign alloc_ready   = !full;
  assign alloc_tag     = w_tail;

  assign commit_valid  = r_entries[w_head].valid && r_entries[w_head].done && !flush;
  assign commit_tag    = w_head;
  assign commit_is_mem = r_entries[w_head].is_mem;
  assign commit_dest   = r_entries[w_head].dest;
  assign commit_addr   = r_entries[w_head].addr;
  assign commit_data   = r_entries[w_head].data;

  assign w_alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign w_commit_fire = commit_valid && commit_ready;
  // A writeback racing an alloc to the same slot sees valid=0 and is dropped.
  assign w_wb_hit      = wb_valid && r_entries[wb_tag].valid && !flush;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush),
    .i_inc (w_commit_fire),
    .o_ptr (w_head)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush),
    .i_inc (w_alloc_fire),
    .o_ptr (w_tail)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
        r_entries[i].done  <= 1'b0;
      end
    end else begin
      if (w_wb_hit) begin
        r_entries[wb_tag].data <= wb_data;
        r_entries[wb_tag].done <= 1'b1;
      end
      if (w_commit_fire) begin
        r_entries[w_head].valid <= 1'b0;
      end
      if (w_alloc_fire) begin
        r_entries[w_tail].valid  <= 1'b1;
        r_entries[w_tail].done   <= 1'b0;
        r_entries[w_tail].is_mem <= alloc_is_mem;
        r_entries[w_tail].dest   <= alloc_dest;
        r_entries[w_tail].addr   <= alloc_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_count <= '0;
    end else if (w_alloc_fire && !w_commit_fire) begin
      r_count <= r_count + (TAG_W+1)'(1);
    end else if (!w_alloc_fire && w_commit_fire) begin
      r_count <= r_count - (TAG_W+1)'(1);
    end
  end
endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param: queue-based reference model checked every cycle plus literal expectations.
module tb_rob_param;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 48;
  localparam int REG_W  = 5;
  localparam int TAG_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alloc_valid, alloc_ready, alloc_is_mem;
  logic [REG_W-1:0]  alloc_dest;
  logic [ADDR_W-1:0] alloc_addr;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic              commit_valid, commit_ready, commit_is_mem;
  logic [TAG_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_dest;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic              flush, full, empty;
  logic [TAG_W:0]    count;

  always #5 clk = ~clk;

  rob_param dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_dest(alloc_dest),
    .alloc_is_mem(alloc_is_mem), .alloc_addr(alloc_addr), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .commit_is_mem(commit_is_mem), .commit_dest(commit_dest), .commit_addr(commit_addr),
    .commit_data(commit_data),
    .flush(flush), .full(full), .empty(empty), .count(count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: the ROB is just a program-ordered queue of live entries.
  typedef struct {
    int                tag;
    logic              is_mem;
    logic [REG_W-1:0]  dest;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                done;
  } ment_t;

  ment_t       mq[$];
  int          m_tail = 0;
  bit          m_init = 1'b0;
  logic [63:0] clog[$];
  int          max_count = 0;

  // Inputs change just after posedge, so at negedge they are exactly what the next edge samples.
  initial begin : compare
    ment_t e;
    bit    exp_cv, cf, af;
    forever begin
      @(negedge clk);
      if (m_init) begin
        exp_cv = (mq.size() > 0) && mq[0].done && !flush;
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("alloc_ready", 64'(alloc_ready), 64'(mq.size() != DEPTH));
        chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
        chk("commit_tag", 64'(commit_tag), 64'((mq.size() > 0) ? mq[0].tag : m_tail));
        chk("commit_valid", 64'(commit_valid), 64'(exp_cv));
        if (exp_cv) begin
          chk("commit_data", commit_data, mq[0].data);
          chk("commit_dest", 64'(commit_dest), 64'(mq[0].dest));
          chk("commit_addr", 64'(commit_addr), 64'(mq[0].addr));
          chk("commit_is_mem", 64'(commit_is_mem), 64'(mq[0].is_mem));
        end
        if (int'(count) > max_count) max_count = int'(count);
        if (commit_valid && commit_ready) clog.push_back(commit_data);
      end
      if (!rst_n || flush) begin
        mq.delete();
        m_tail = 0;
        m_init = 1'b1;
      end else if (m_init) begin
        cf = (mq.size() > 0) && mq[0].done && commit_ready;
        af = alloc_valid && (mq.size() < DEPTH);
        if (wb_valid) begin
          foreach (mq[i]) begin
            if (mq[i].tag == int'(wb_tag)) begin
              e = mq[i];
              e.data = wb_data;
              e.done = 1'b1;
              mq[i] = e;
            end
          end
        end
        if (cf) void'(mq.pop_front());
        if (af) begin
          e.tag    = m_tail;
          e.is_mem = alloc_is_mem;
          e.dest   = alloc_dest;
          e.addr   = alloc_addr;
          e.data   = '0;
          e.done   = 1'b0;
          mq.push_back(e);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; wb_valid = 1'b0; commit_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin : stim
    logic [TAG_W-1:0] prev_tag, t0, t1;
    logic [TAG_W-1:0] ftag [5];
    int               n;

    rst_n = 1'b0; idle();
    alloc_dest = '0; alloc_is_mem = 1'b0; alloc_addr = '0;
    wb_tag = '0; wb_data = '0;
    prev_tag = '0;

    // Reset held for two edges
    cyc(); cyc();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_commit_tag", 64'(commit_tag), 64'd0);
    chk("rst_commit_data", commit_data, 64'd0);
    chk("rst_commit_addr", 64'(commit_addr), 64'd0);
    chk("rst_commit_dest", 64'(commit_dest), 64'd0);
    chk("rst_commit_is_mem", 64'(commit_is_mem), 64'd0);
    rst_n = 1'b1;

    // Fill to full, then a refused ninth alloc
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid = 1'b1; alloc_dest = REG_W'(i);
      cyc();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_alloc_ready", 64'(alloc_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd8);
    cyc();
    chk("ninth_count", 64'(count), 64'd8);
    chk("ninth_tail", 64'(alloc_tag), 64'd0);
    alloc_valid = 1'b0;

    // Reset mid-operation drops everything
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_commit_valid", 64'(commit_valid), 64'd0);

    // Out-of-order writeback, in-order commit
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_dest = REG_W'(i + 1);
      cyc();
    end
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = 3'd2; wb_data = 64'hC; cyc();
    wb_tag = 3'd1; wb_data = 64'hB; cyc();
    chk("ooo_wait_cv", 64'(commit_valid), 64'd0);
    wb_tag = 3'd0; wb_data = 64'hA; cyc();
    wb_valid = 1'b0;
    chk("ooo_head_cv", 64'(commit_valid), 64'd1);
    chk("ooo_head_data", commit_data, 64'hA);
    clog.delete();
    commit_ready = 1'b1; cyc();
    chk("ooo_second_data", commit_data, 64'hB);
    chk("ooo_second_tag", 64'(commit_tag), 64'd1);
    cyc();
    chk("ooo_third_data", commit_data, 64'hC);
    cyc();
    commit_ready = 1'b0;
    chk("ooo_drained", 64'(empty), 64'd1);
    chk("ooo_log_size", 64'(clog.size()), 64'd3);
    if (clog.size() == 3) begin
      chk("ooo_log0", clog[0], 64'hA);
      chk("ooo_log1", clog[1], 64'hB);
      chk("ooo_log2", clog[2], 64'hC);
    end

    // Wrap-around stream with immediate writeback
    flush = 1'b1; cyc(); flush = 1'b0;
    clog.delete(); max_count = 0;
    for (int k = 0; k < 22; k++) begin
      alloc_valid = (k < 20); alloc_dest = REG_W'(k); alloc_is_mem = 1'b0;
      if (k < 20) chk("wrap_alloc_tag", 64'(alloc_tag), 64'(k % 8));
      wb_valid = (k >= 1 && k <= 20); wb_tag = prev_tag; wb_data = 64'(256 + k - 1);
      commit_ready = 1'b1;
      prev_tag = alloc_tag;
      cyc();
    end
    idle();
    chk("wrap_log_size", 64'(clog.size()), 64'd20);
    if (clog.size() == 20)
      for (int j = 0; j < 20; j++) chk("wrap_order", clog[j], 64'(256 + j));
    chk("wrap_max_count_le8", 64'(max_count <= 8), 64'd1);
    chk("wrap_empty", 64'(empty), 64'd1);

    // Memory vs register entries, head held while commit_ready is low
    t0 = alloc_tag;
    alloc_valid = 1'b1; alloc_is_mem = 1'b1; alloc_addr = 48'h1000; alloc_dest = '0; cyc();
    t1 = alloc_tag;
    alloc_is_mem = 1'b0; alloc_addr = '0; alloc_dest = 5'd5; cyc();
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = t0; wb_data = 64'h11; cyc();
    wb_tag = t1; wb_data = 64'h22; cyc();
    wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mem_hold_cv", 64'(commit_valid), 64'd1);
      chk("mem_hold_is_mem", 64'(commit_is_mem), 64'd1);
      chk("mem_hold_addr", 64'(commit_addr), 64'h1000);
      chk("mem_hold_tag", 64'(commit_tag), 64'(t0));
      cyc();
    end
    commit_ready = 1'b1; cyc();
    chk("reg_is_mem", 64'(commit_is_mem), 64'd0);
    chk("reg_dest", 64'(commit_dest), 64'd5);
    chk("reg_data", commit_data, 64'h22);
    cyc();
    commit_ready = 1'b0;
    chk("memreg_empty", 64'(empty), 64'd1);

    // Flush with 5 entries, 2 done, colliding with alloc/commit/writeback
    for (int i = 0; i < 5; i++) begin
      ftag[i] = alloc_tag;
      alloc_valid = 1'b1; alloc_dest = REG_W'(i); cyc();
    end
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = ftag[0]; wb_data = 64'h55; cyc();
    wb_tag = ftag[1]; wb_data = 64'h66; cyc();
    wb_valid = 1'b0;
    chk("preflush_cv", 64'(commit_valid), 64'd1);
    chk("preflush_count", 64'(count), 64'd5);
    n = clog.size();
    flush = 1'b1; alloc_valid = 1'b1; commit_ready = 1'b1;
    wb_valid = 1'b1; wb_tag = ftag[2]; wb_data = 64'h99;
    #1;
    chk("flush_cv_masked", 64'(commit_valid), 64'd0);
    chk("flush_alloc_ready", 64'(alloc_ready), 64'd1);
    cyc();
    flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
    chk("postflush_count", 64'(count), 64'd0);
    chk("postflush_empty", 64'(empty), 64'd1);
    chk("postflush_tail", 64'(alloc_tag), 64'd0);
    chk("postflush_head", 64'(commit_tag), 64'd0);
    chk("flush_no_commit", 64'(clog.size()), 64'(n));
    wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 64'h77; cyc();
    wb_valid = 1'b0;
    chk("stale_wb_cv", 64'(commit_valid), 64'd0);
    chk("stale_wb_count", 64'(count), 64'd0);
    idle();
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
